// File: rtl/ps2_mouse_port.sv
// ps2_mouse_port
//   Z80 I/O-port front end for the MiSTer PS/2 mouse packet bus. Accumulates
//   signed X/Y motion from hps_io packets with saturation to [-128,+127],
//   tracks buttons, and serves four read ports at BASE_ADDR..BASE_ADDR+3:
//     +0 X accumulator, +1 Y accumulator,
//     +2 {ovf, irq_pend, 3'b0, buttons{M,R,L}}, +3 8'h00.
//   Reads are snapshot-and-subtract: the value shown to the CPU is latched at
//   the start of the read and subtracted once the read ends, so motion that
//   arrives during a read is kept.
//
//   Optional feature macro: MOUSE_IRQ_EN (interrupt request on new motion or
//   button change, cleared by a port-2 read). Undefined: irq_n is tied high
//   and status bit 6 reads 0.
//
// Ports
//   clk        in  1   CPU clock, rising edge
//   reset_n    in  1   synchronous reset, active-low
//   ps2_mouse  in  25  [24] toggle, [23:16] Y low, [15:8] X low, [7:0] status
//   io_addr    in  8   CPU I/O address
//   io_rd      in  1   high during a non-M1 I/O read
//   io_sel     out 1   address decode hit (combinational)
//   io_dout    out 8   read data, 8'h00 when not reading this block
//   mouse_x    out 8   live signed X accumulator
//   mouse_y    out 8   live signed Y accumulator
//   mouse_b    out 3   live buttons {M,R,L}
//   irq_n      out 1   active-low interrupt request
module ps2_mouse_port #(
  parameter logic [7:0] BASE_ADDR = 8'h30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  input  logic [7:0]  io_addr,
  input  logic        io_rd,
  output logic        io_sel,
  output logic [7:0]  io_dout,
  output logic [7:0]  mouse_x,
  output logic [7:0]  mouse_y,
  output logic [2:0]  mouse_b,
  output logic        irq_n
);

  logic [24:0]       r_pkt;
  logic              r_tog_prev;
  logic signed [7:0] r_acc_x;
  logic signed [7:0] r_acc_y;
  logic [2:0]        r_btn;
  logic              r_ovf;
  logic [7:0]        r_snap;
  logic [1:0]        r_port;
  logic              r_rd_act;

  logic              w_stb;
  logic signed [8:0] w_dx;
  logic signed [8:0] w_dy;
  logic              w_rd_cur;
  logic              w_rd_start;
  logic              w_rd_end;
  logic              w_clr_x;
  logic              w_clr_y;
  logic              w_clr_s;
  logic [7:0]        w_sub_x;
  logic [7:0]        w_sub_y;
  logic signed [9:0] w_sum_x;
  logic signed [9:0] w_sum_y;
  logic              w_sat_x;
  logic              w_sat_y;
  logic              w_irq_pend;
  logic [7:0]        w_status;
  logic [7:0]        w_rd_mux;
  logic              w_unused_bits;

  // Clamp a 10-bit intermediate sum to the signed 8-bit range.
  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)
      sat8 = 8'sd127;
    else if (v < -10'sd128)
      sat8 = -8'sd128;
    else
      sat8 = v[7:0];
  endfunction

  function automatic logic is_sat(input logic signed [9:0] v);
    is_sat = (v > 10'sd127) || (v < -10'sd128);
  endfunction

  // A packet is flagged by any change of the registered toggle bit.
  assign w_stb = r_pkt[24] ^ r_tog_prev;
  assign w_dx  = w_stb ? {r_pkt[4], r_pkt[15:8]}  : 9'sd0;
  assign w_dy  = w_stb ? {r_pkt[5], r_pkt[23:16]} : 9'sd0;

  assign io_sel     = (io_addr[7:2] == BASE_ADDR[7:2]);
  assign w_rd_cur   = io_rd & io_sel;
  assign w_rd_start = w_rd_cur & ~r_rd_act;
  assign w_rd_end   = r_rd_act & ~w_rd_cur;

  assign w_clr_x = w_rd_end & (r_port == 2'd0);
  assign w_clr_y = w_rd_end & (r_port == 2'd1);
  assign w_clr_s = w_rd_end & (r_port == 2'd2);

  // Subtract the snapshot the CPU saw, not the live value, so any delta
  // landing in the same cycle or during the read is preserved.
  assign w_sub_x = w_clr_x ? r_snap : 8'h00;
  assign w_sub_y = w_clr_y ? r_snap : 8'h00;

  assign w_sum_x = {{2{r_acc_x[7]}}, r_acc_x} + {w_dx[8], w_dx}
                 - {{2{w_sub_x[7]}}, w_sub_x};
  assign w_sum_y = {{2{r_acc_y[7]}}, r_acc_y} + {w_dy[8], w_dy}
                 - {{2{w_sub_y[7]}}, w_sub_y};
  assign w_sat_x = is_sat(w_sum_x);
  assign w_sat_y = is_sat(w_sum_y);

  assign w_status = {r_ovf, w_irq_pend, 3'b000, r_btn};

  always_comb begin
    w_rd_mux = 8'h00;
    case (io_addr[1:0])
      2'd0:    w_rd_mux = r_acc_x;
      2'd1:    w_rd_mux = r_acc_y;
      2'd2:    w_rd_mux = w_status;
      default: w_rd_mux = 8'h00;
    endcase
  end

  assign io_dout = w_rd_cur ? r_snap : 8'h00;
  assign mouse_x = r_acc_x;
  assign mouse_y = r_acc_y;
  assign mouse_b = r_btn;

  // Status bits 7:6 and bit 3 of the packet carry nothing used here.
  assign w_unused_bits = ^{r_pkt[7:6], r_pkt[3]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Seeding the previous toggle from the live input prevents a phantom
      // packet on reset release.
      r_pkt      <= ps2_mouse;
      r_tog_prev <= ps2_mouse[24];
      r_acc_x    <= 8'sd0;
      r_acc_y    <= 8'sd0;
      r_btn      <= 3'b000;
      r_ovf      <= 1'b0;
      r_snap     <= 8'h00;
      r_port     <= 2'd0;
      r_rd_act   <= 1'b0;
    end else begin
      r_pkt      <= ps2_mouse;
      r_tog_prev <= r_pkt[24];
      r_acc_x    <= sat8(w_sum_x);
      r_acc_y    <= sat8(w_sum_y);
      r_rd_act   <= w_rd_cur;
      if (w_stb)
        r_btn <= r_pkt[2:0];
      if (w_rd_start) begin
        r_snap <= w_rd_mux;
        r_port <= io_addr[1:0];
      end
      // A new overflow wins over a clear in the same cycle.
      r_ovf <= w_sat_x | w_sat_y | (r_ovf & ~w_clr_s);
    end
  end

`ifdef MOUSE_IRQ_EN
  logic r_irq_pend;
  logic r_irq_n;
  logic w_irq_set;

  assign w_irq_set = w_stb & ((w_dx != 9'sd0) || (w_dy != 9'sd0) ||
                              (r_pkt[2:0] != r_btn));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_irq_pend <= 1'b0;
      r_irq_n    <= 1'b1;
    end else begin
      r_irq_pend <= w_irq_set | (r_irq_pend & ~w_clr_s);
      r_irq_n    <= ~r_irq_pend;
    end
  end

  assign w_irq_pend = r_irq_pend;
  assign irq_n      = r_irq_n;
`else
  assign w_irq_pend = 1'b0;
  assign irq_n      = 1'b1;
`endif

endmodule

// File: doc/ps2_mouse_port.md
# ps2_mouse_port

Z80 I/O-port front end for the MiSTer PS/2 mouse packet bus. Consumes the 25-bit `ps2_mouse` packet word driven by `hps_io`, accumulates signed X/Y motion with saturation, tracks buttons and produces the byte the CPU reads at ports BASE..BASE+3. Sits between `hps_io` and the CPU `io_dout` mux. Snapshot-and-subtract clear-on-read semantics lose no motion that arrives during a CPU read.

## Interface
- `BASE_ADDR`, default 8'h30: port base; bits [1:0] must be 0.
- `clk`  in  1: CPU clock; all logic on rising edge.
- `reset_n`  in  1: synchronous reset, active-low.
- `ps2_mouse`  in  25: [24] packet toggle, [23:16] Y delta low byte, [15:8] X delta low byte, [7:0] status (b0 L, b1 R, b2 M, b4 X sign, b5 Y sign).
- `io_addr`  in  8: CPU address [7:0].
- `io_rd`  in  1: level; high while CPU performs a non-M1 I/O read.
- `io_sel`  out  1: combinational, `io_addr[7:2]==BASE_ADDR[7:2]`.
- `io_dout`  out  8: read data, 8'h00 when not selected.
- `mouse_x`, `mouse_y`  out  8: live signed accumulators.
- `mouse_b`  out  3: live buttons {M,R,L}.
- `irq_n`  out  1: active-low interrupt request (see Configuration).

## Operation
- Packet detect: register `ps2_mouse` each cycle. Strobe when registered [24] differs from previous registered [24]. During reset the previous-toggle register loads the current toggle, so no packet is detected on reset release.
- Deltas are 9-bit two's complement: {sign, byte}. On strobe, `acc + delta` is computed in 10 bits and saturated to [-128, +127]. If it saturates, sticky `ovf` is set. `mouse_b` loads status[2:0].
- Read cycle, address decode on `io_addr[1:0]`:
  - On the first cycle `io_rd && io_sel` (rising edge), `snap` latches the selected register: 0 → X acc, 1 → Y acc, 2 → {ovf, irq_pend, 3'b0, b[2:0]}, 3 → 8'h00.
  - `io_dout` = `snap` while `io_rd && io_sel`, else 8'h00.
  - On the cycle after `io_rd` falls with the latched port 0/1: acc ← sat(acc − snap + delta_if_strobe_this_cycle). Motion received during the read is retained. Port 2 falling: `ovf` cleared; `irq_pend` cleared.
- Simultaneous strobe and clear: both apply in one update. A set of `ovf`/`irq_pend` wins over a clear.
- Reset: accs 0, `mouse_b` 0, `ovf` 0, `irq_pend` 0, `snap` 0, `io_dout` 8'h00, `irq_n` 1.

## Timing
- Packet to accumulator: acc updated on the 2nd rising edge after `ps2_mouse[24]` toggles. Packets must be ≥3 cycles apart; closer packets may be merged or lost.
- Read latency: `io_dout` valid from 1 cycle after `io_rd` rises until `io_rd` falls. `io_rd` must be held ≥2 cycles. Z80 T2–T3 satisfies this at 4 MHz.
- Clear takes effect 1 cycle after `io_rd` falls. A back-to-back read starting that cycle sees the cleared value.
- Reset asserted mid-read: all state returns to reset values on that edge. No clear is applied after reset.

## Configuration
- `MOUSE_IRQ_EN` defined:
  - `irq_pend` is set on any strobe with nonzero delta or a button change.
  - `irq_n` = ~`irq_pend`, registered, so it lags the set by 1 cycle.
  - `irq_pend` is cleared only by a port-2 read.
- `MOUSE_IRQ_EN` undefined:
  - `irq_pend` logic is removed.
  - `irq_n` is constant 1; status bit 6 reads 0.

## Test plan
- Reset release with toggle=1 → no packet, accs 0, `io_dout` 8'h00, `irq_n`=1.
- Three packets X=+100 each (status 0x00, byte 0x64) → `mouse_x` 100, 127 (sat), 127; port-2 read returns bit7=1, then a second read returns bit7=0.
- Packet X=−5 (status 0x10, byte 0xFB) then port-0 read → `io_dout` 8'hFB; `mouse_x`=0 one cycle after `io_rd` falls.
- Port-1 read of Y=10 while a Y=+3 packet lands mid-read → `io_dout` stays 8'h0A for the whole read; after the read `mouse_y`=3.
- Status 0x05 packet with zero deltas → port 2 reads 8'h45 with `MOUSE_IRQ_EN` (`irq_n` low 3 cycles after toggle), 8'h05 without; `irq_n` returns high after the read.
- `reset_n` low during a port-0 read of X=20 → X=0, `io_dout`=0 next cycle, no subtract applied after release.
